// File: rtl/prog_freq_divider_pkg.sv
// Package for prog_freq_divider: default divisors and the select-width helper.
package prog_freq_divider_pkg;
`include "prog_freq_divider_defs.vh"

  localparam logic [23:0] DIV_2HZ = `PFD_DIV_2HZ;
  localparam logic [23:0] DIV_5HZ = `PFD_DIV_5HZ;
  localparam logic [23:0] DIV_9HZ = `PFD_DIV_9HZ;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fdiv_chan.sv
// One divider channel.
//   clk, reset   system clock, synchronous active-high reset
//   en           run enable for this channel
//   sync         restart strobe shared by all channels
//   ld, ld_div   divisor load (already qualified by channel select)
//   q, tick      registered divided clock and its rising-edge pulse
module fdiv_chan #(
  parameter int               DIV_W = 24,
  parameter logic [DIV_W-1:0] DEF_D = DIV_W'(2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_div,
  output logic             q,
  output logic             tick
);
`include "prog_freq_divider_defs.vh"

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  logic [DIV_W-1:0] d, p, cnt;
  logic [DIV_W-1:0] p_nxt, src, d_new, cnt_inc;
  logic             run, wrap;

  always_comb begin
    run     = en && (d >= TWO);
    wrap    = (cnt == d - ONE);
    p_nxt   = ld ? ld_div : p;
    // A sync restart picks up a load from the same cycle; a natural wrap
    // commits only what was already pending, so a same-cycle load waits.
    src     = (run && sync) ? p_nxt : p;
    d_new   = (src == ONE) ? TWO : src;
    cnt_inc = cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d    <= DEF_D;
      p    <= DEF_D;
      cnt  <= DEF_D - ONE;
      q    <= 1'b0;
      tick <= 1'b0;
    end else begin
      p <= p_nxt;
      if (!run) begin
        // Idle: keep the counter parked at D-1 so enabling wraps immediately.
        d    <= d_new;
        cnt  <= d_new - ONE;
        q    <= 1'b0;
        tick <= 1'b0;
      end else if (wrap || sync) begin
        d <= d_new;
        if (d_new >= TWO) begin
          cnt  <= '0;
          q    <= 1'b1;
          tick <= 1'b1;
        end else begin
          // Committed divisor stops the channel at this restart point.
          cnt  <= d_new - ONE;
          q    <= 1'b0;
          tick <= 1'b0;
        end
      end else begin
        cnt  <= cnt_inc;
        q    <= (cnt_inc < `PFD_HALF(d));
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_freq_divider_defs.vh
// Shared constants for the programmable frequency divider.
//   PFD_CLK_HZ     nominal system clock rate
//   PFD_DIV_xHZ    reset divisors for 2/5/9 Hz outputs at PFD_CLK_HZ
//   PFD_HALF(d)    length of the high phase, ceil(d/2), written so it never overflows
`ifndef PROG_FREQ_DIVIDER_DEFS_VH
`define PROG_FREQ_DIVIDER_DEFS_VH

`define PFD_CLK_HZ   25_000_000
`define PFD_DIV_2HZ  24'd12_500_000
`define PFD_DIV_5HZ  24'd5_000_000
`define PFD_DIV_9HZ  24'd2_777_778

`define PFD_HALF(d) ((d) - ((d) >> 1))

`endif

// File: rtl/prog_freq_divider.sv
// Multi-channel programmable clock divider.
//   clk, reset   system clock, synchronous active-high reset
//   en[NCH]      per-channel run enable
//   sync         restarts all running channels in phase
//   ld/ld_ch/ld_div  load a pending divisor into one channel; out-of-range ld_ch ignored
//   q[NCH]       divided clocks (high ceil(D/2), low floor(D/2) cycles)
//   tick[NCH]    one-cycle pulse coincident with each q rising edge
module prog_freq_divider
  import prog_freq_divider_pkg::*;
#(
  parameter int                   NCH     = 3,
  parameter int                   DIV_W   = 24,
  parameter logic [NCH*DIV_W-1:0] DEF_DIV = {DIV_9HZ, DIV_5HZ, DIV_2HZ}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          en,
  input  logic                    sync,
  input  logic                    ld,
  input  logic [sel_w(NCH)-1:0]   ld_ch,
  input  logic [DIV_W-1:0]        ld_div,
  output logic [NCH-1:0]          q,
  output logic [NCH-1:0]          tick
);

  localparam int SEL_W = sel_w(NCH);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    fdiv_chan #(
      .DIV_W (DIV_W),
      .DEF_D (DEF_DIV[i*DIV_W +: DIV_W])
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .sync   (sync),
      .ld     (ld && (ld_ch == SEL_W'(i))),
      .ld_div (ld_div),
      .q      (q[i]),
      .tick   (tick[i])
    );
  end

endmodule
